// File: rtl/nes_rom_writer.sv
// nes_rom_writer: parses the iNES header from the SD byte stream, skips the
// optional trainer, and writes PRG then CHR bytes to memory via req/ack.
// A small FIFO absorbs memory stalls because the input stream cannot stall.
module nes_rom_writer #(
  parameter int unsigned       ADDR_W   = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000,
  parameter int unsigned       FIFO_LOG = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_start,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [7:0]        mapper,
  output logic              mirroring,
  output logic              four_screen,
  output logic              battery,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic              hdr_valid,
  output logic              hdr_error,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned DEPTH   = 1 << FIFO_LOG;
  localparam int unsigned ENTRY_W = ADDR_W + 8;

  typedef enum logic [2:0] {
    S_HDR, S_TRAINER, S_PRG, S_CHR, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          hdr_cnt_q, hdr_cnt_d;
  logic                magic_bad_q, magic_bad_d;
  logic [7:0]          prg_q, prg_d;
  logic [7:0]          chr_q, chr_d;
  logic [7:0]          flags6_q, flags6_d;
  logic [3:0]          flags7_q, flags7_d;   // only the upper nibble of flags7 matters
  logic                hdr_valid_q, hdr_valid_d;
  logic                hdr_error_q, hdr_error_d;
  logic                overflow_q, overflow_d;
  logic [21:0]         cnt_q, cnt_d;         // bytes remaining in the current section
  logic [ADDR_W-1:0]   waddr_q, waddr_d;     // address of the next byte pushed
  logic [FIFO_LOG:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG:0]   rd_ptr_q, rd_ptr_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [7:0]          mdata_q, mdata_d;

  logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
  logic [ENTRY_W-1:0]  rd_entry;
  logic                push_en;
  logic                fifo_empty;
  logic                fifo_full;
  logic [31:0]         prg_bytes;
  logic [21:0]         chr_bytes;
  logic                prg_bad;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_LOG] != rd_ptr_q[FIFO_LOG]) &&
                      (wr_ptr_q[FIFO_LOG-1:0] == rd_ptr_q[FIFO_LOG-1:0]);
  assign rd_entry   = fifo_mem[rd_ptr_q[FIFO_LOG-1:0]];

  assign prg_bytes  = {10'd0, prg_q, 14'd0};
  assign chr_bytes  = {1'b0, chr_q, 13'd0};
  assign prg_bad    = (prg_q == 8'd0) || (prg_bytes > 32'(CHR_BASE));

  // Next-state logic: header parsing, section counting, FIFO push and memory-port pop
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    magic_bad_d = magic_bad_q;
    prg_d       = prg_q;
    chr_d       = chr_q;
    flags6_d    = flags6_q;
    flags7_d    = flags7_q;
    hdr_valid_d = hdr_valid_q;
    hdr_error_d = hdr_error_q;
    overflow_d  = overflow_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    req_d       = req_q;
    maddr_d     = maddr_q;
    mdata_d     = mdata_q;
    push_en     = 1'b0;

    // Memory port: drop req the cycle after ack, then pop the next entry
    if (req_q && mem_ack) begin
      req_d = 1'b0;
    end
    if (!req_q && !fifo_empty) begin
      req_d    = 1'b1;
      maddr_d  = rd_entry[ENTRY_W-1:8];
      mdata_d  = rd_entry[7:0];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case (state_q)
      S_HDR: begin
        if (din_valid) begin
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          unique case (hdr_cnt_q)
            4'd0: if (din != 8'h4E) magic_bad_d = 1'b1;
            4'd1: if (din != 8'h45) magic_bad_d = 1'b1;
            4'd2: if (din != 8'h53) magic_bad_d = 1'b1;
            4'd3: begin
              if (magic_bad_q || (din != 8'h1A)) begin
                state_d     = S_ERR;
                hdr_error_d = 1'b1;
              end
            end
            4'd4: prg_d    = din;
            4'd5: chr_d    = din;
            4'd6: flags6_d = din;
            4'd7: flags7_d = din[7:4];
            4'd15: begin
              if (prg_bad) begin
                state_d     = S_ERR;
                hdr_error_d = 1'b1;
              end else begin
                hdr_valid_d = 1'b1;
                waddr_d     = '0;
                if (flags6_q[2]) begin
                  state_d = S_TRAINER;
                  cnt_d   = 22'd512;
                end else begin
                  state_d = S_PRG;
                  cnt_d   = prg_bytes[21:0];
                end
              end
            end
            default: ;
          endcase
        end
      end

      S_TRAINER: begin
        if (din_valid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 22'd1) begin
            state_d = S_PRG;
            cnt_d   = prg_bytes[21:0];
          end
        end
      end

      S_PRG, S_CHR: begin
        if (din_valid) begin
          // A dropped byte still consumes its address so later bytes stay aligned
          if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            push_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          waddr_d = waddr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == 22'd1) begin
            if ((state_q == S_PRG) && (chr_q != 8'd0)) begin
              state_d = S_CHR;
              cnt_d   = chr_bytes;
              waddr_d = CHR_BASE;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        if (fifo_empty && !req_q) state_d = S_DONE;
      end

      S_DONE, S_ERR: ;

      default: state_d = S_HDR;
    endcase

    // load_start wins over everything, including a pending write
    if (load_start) begin
      state_d     = S_HDR;
      hdr_cnt_d   = '0;
      magic_bad_d = 1'b0;
      prg_d       = '0;
      chr_d       = '0;
      flags6_d    = '0;
      flags7_d    = '0;
      hdr_valid_d = 1'b0;
      hdr_error_d = 1'b0;
      overflow_d  = 1'b0;
      cnt_d       = '0;
      waddr_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      req_d       = 1'b0;
      maddr_d     = '0;
      mdata_d     = '0;
      push_en     = 1'b0;
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_HDR;
      hdr_cnt_q   <= '0;
      magic_bad_q <= 1'b0;
      prg_q       <= '0;
      chr_q       <= '0;
      flags6_q    <= '0;
      flags7_q    <= '0;
      hdr_valid_q <= 1'b0;
      hdr_error_q <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_q       <= 1'b0;
      maddr_q     <= '0;
      mdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      magic_bad_q <= magic_bad_d;
      prg_q       <= prg_d;
      chr_q       <= chr_d;
      flags6_q    <= flags6_d;
      flags7_q    <= flags7_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_error_q <= hdr_error_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_q       <= req_d;
      maddr_q     <= maddr_d;
      mdata_q     <= mdata_d;
    end
  end

  // FIFO storage: {addr, data} per entry, no reset needed (pointers gate validity)
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr_q[FIFO_LOG-1:0]] <= {waddr_q, din};
  end

  assign mem_addr    = maddr_q;
  assign mem_din     = mdata_q;
  assign mem_req     = req_q;
  assign mapper      = {flags7_q, flags6_q[7:4]};
  assign mirroring   = flags6_q[0];
  assign four_screen = flags6_q[3];
  assign battery     = flags6_q[1];
  assign prg_banks   = prg_q;
  assign chr_banks   = chr_q;
  assign hdr_valid   = hdr_valid_q;
  assign hdr_error   = hdr_error_q;
  assign overflow    = overflow_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_nes_rom_writer.sv
// Directed bench for nes_rom_writer: expected writes are queued as bytes are
// driven and compared when the memory model accepts each request.
module tb_nes_rom_writer;

  localparam logic [21:0] CHR_BASE = 22'h200000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load_start;
  logic [7:0]  din;
  logic        din_valid;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mapper;
  logic        mirroring;
  logic        four_screen;
  logic        battery;
  logic [7:0]  prg_banks;
  logic [7:0]  chr_banks;
  logic        hdr_valid;
  logic        hdr_error;
  logic        overflow;
  logic        done;

  always #5 clk = ~clk;

  nes_rom_writer #(
    .ADDR_W  (22),
    .CHR_BASE(22'h200000),
    .FIFO_LOG(4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_start (load_start),
    .din        (din),
    .din_valid  (din_valid),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mapper     (mapper),
    .mirroring  (mirroring),
    .four_screen(four_screen),
    .battery    (battery),
    .prg_banks  (prg_banks),
    .chr_banks  (chr_banks),
    .hdr_valid  (hdr_valid),
    .hdr_error  (hdr_error),
    .overflow   (overflow),
    .done       (done)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  int          n_hi     = 0;
  logic        hold_ack = 1'b0;
  logic [29:0] exp_q [$];

  function automatic logic [7:0] dat(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: ack one cycle after a request is seen, compare against the scoreboard
  task automatic service_mem();
    logic [29:0] e;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && !hold_ack) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", mem_addr, mem_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write", 32'({mem_addr, mem_din}), 32'(e));
      end
      n_writes++;
      if (mem_addr >= CHR_BASE) n_hi++;
      mem_ack = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    service_mem();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic send_header(input logic [7:0] m3, input logic [7:0] p, input logic [7:0] c,
                             input logic [7:0] f6, input logic [7:0] f7);
    logic [7:0] h [16];
    for (int i = 0; i < 16; i++) h[i] = 8'h00;
    h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = m3;
    h[4] = p;     h[5] = c;     h[6] = f6;    h[7] = f7;
    for (int i = 0; i < 16; i++) send(h[i], 0);
  endtask

  task automatic send_rom(input logic [21:0] start, input int n, input int idle);
    logic [21:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, dat(a)});
      send(dat(a), idle);
      a = a + 22'd1;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || mem_req) && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req"},      32'(mem_req),   32'd0);
    check({tag, "_addr"},     32'(mem_addr),  32'd0);
    check({tag, "_data"},     32'(mem_din),   32'd0);
    check({tag, "_mapper"},   32'(mapper),    32'd0);
    check({tag, "_flags"},    32'({mirroring, four_screen, battery}), 32'd0);
    check({tag, "_banks"},    32'({prg_banks, chr_banks}), 32'd0);
    check({tag, "_status"},   32'({hdr_valid, hdr_error, overflow, done}), 32'd0);
  endtask

  initial begin
    int          w0;
    int          h0;
    logic [21:0] a;

    resetn     = 1'b0;
    load_start = 1'b0;
    din        = 8'h00;
    din_valid  = 1'b0;
    mem_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    resetn = 1'b1;
    tick();

    // Normal image: PRG 16 KiB, CHR 8 KiB, vertical mirroring
    send_header(8'h1A, 8'd1, 8'd1, 8'h01, 8'h00);
    check("a_hdr_valid", 32'(hdr_valid), 32'd1);
    check("a_hdr_error", 32'(hdr_error), 32'd0);
    check("a_mapper",    32'(mapper),    32'h00);
    check("a_mirroring", 32'(mirroring), 32'd1);
    check("a_banks",     32'({prg_banks, chr_banks}), 32'h0101);
    w0 = n_writes;
    h0 = n_hi;
    send_rom(22'd0, 16384, 1);
    send_rom(CHR_BASE, 8192, 1);
    wait_done("a_done", 200);
    check("a_writes",   32'(n_writes - w0), 32'd24576);
    check("a_chr_writes", 32'(n_hi - h0),   32'd8192);
    check("a_overflow", 32'(overflow),      32'd0);

    pulse_load();
    check("b_done_cleared", 32'(done), 32'd0);

    // Bad magic byte 3: error, and nothing is ever written
    w0 = n_writes;
    send(8'h4E, 0); send(8'h45, 0); send(8'h53, 0); send(8'h1B, 0);
    check("b_err_at_byte3", 32'(hdr_error), 32'd1);
    for (int i = 4; i < 16; i++) send((i == 4) ? 8'd1 : 8'd0, 0);
    for (int i = 0; i < 64; i++) send(8'(i), 0);
    repeat (4) tick();
    check("b_hdr_error", 32'(hdr_error), 32'd1);
    check("b_hdr_valid", 32'(hdr_valid), 32'd0);
    check("b_no_writes", 32'(n_writes - w0), 32'd0);
    check("b_no_req",    32'(mem_req), 32'd0);

    // PRG size boundaries against CHR_BASE
    pulse_load();
    check("c_err_cleared", 32'(hdr_error), 32'd0);
    send_header(8'h1A, 8'h81, 8'd0, 8'h00, 8'h00);
    check("c_prg81_error", 32'({hdr_valid, hdr_error}), 32'b01);
    pulse_load();
    send_header(8'h1A, 8'h00, 8'd1, 8'h00, 8'h00);
    check("c_prg0_error", 32'({hdr_valid, hdr_error}), 32'b01);
    pulse_load();
    send_header(8'h1A, 8'h80, 8'd0, 8'h00, 8'h00);
    check("c_prg80_ok", 32'({hdr_valid, hdr_error}), 32'b10);
    check("c_prg80_banks", 32'(prg_banks), 32'h80);
    pulse_load();

    // Trainer skip, then overflow under a stalled memory, then abort mid-PRG
    send_header(8'h1A, 8'd1, 8'd1, 8'h04, 8'h00);
    check("d_hdr_valid", 32'(hdr_valid), 32'd1);
    for (int i = 0; i < 512; i++) send(8'hEE, 0);
    send_rom(22'd0, 8, 1);
    wait_idle("d_first_prg", 100);
    hold_ack = 1'b1;
    a = 22'd8;
    // One write in flight plus 16 FIFO entries are accepted; the rest are dropped
    for (int k = 0; k < 20; k++) begin
      if (k < 17) exp_q.push_back({a, dat(a)});
      send(dat(a), 0);
      a = a + 22'd1;
    end
    check("d_overflow", 32'(overflow), 32'd1);
    repeat (20) tick();
    check("d_req_held",  32'(mem_req),  32'd1);
    check("d_addr_held", 32'(mem_addr), 32'd8);
    hold_ack = 1'b0;
    wait_idle("d_after_stall", 200);
    send_rom(a, 8, 1);
    a = a + 22'd8;
    wait_idle("d_resumed", 100);
    check("d_overflow_sticky", 32'(overflow), 32'd1);
    hold_ack = 1'b1;
    send_rom(a, 1, 0);
    repeat (3) tick();
    check("d_req_before_abort", 32'(mem_req), 32'd1);
    pulse_load();
    check_cleared("abort");
    exp_q.delete();
    hold_ack = 1'b0;
    repeat (3) tick();
    check("d_req_dropped", 32'(mem_req), 32'd0);

    // Fresh header after abort: PRG only, CHR RAM
    send_header(8'h1A, 8'd1, 8'd0, 8'h1A, 8'h40);
    check("e_hdr_valid", 32'(hdr_valid), 32'd1);
    check("e_mapper",    32'(mapper),    32'h41);
    check("e_flags",     32'({mirroring, four_screen, battery}), 32'b011);
    check("e_banks",     32'({prg_banks, chr_banks}), 32'h0100);
    w0 = n_writes;
    h0 = n_hi;
    send_rom(22'd0, 16384, 1);
    wait_done("e_done", 200);
    check("e_writes",   32'(n_writes - w0), 32'd16384);
    check("e_no_chr",   32'(n_hi - h0),     32'd0);
    check("e_overflow", 32'(overflow),      32'd0);
    repeat (4) tick();
    check("e_still_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
